// File: rtl/fetch_unit_pkg.sv
// Shared front-end package: branch redirect codes (produced by branch_unit,
// consumed by fetch_unit), ALU compare-op encodings used by branch_unit,
// and fetch constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_TAKEN = 2'b01,
        BR_JUMP  = 2'b10,
        BR_RSVD  = 2'b11
    } br_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5
    } cmp_op_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Only TAKEN and JUMP steer the front end; the reserved code is ignored.
    function automatic logic is_redirect(input logic [1:0] br);
        return (br == BR_TAKEN) || (br == BR_JUMP);
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch unit.
//   pc       : current fetch address
//   redirect : take target this cycle (highest priority)
//   target   : redirect address, forced word-aligned
//   advance  : step sequentially by 4 (wraps mod 2^32)
//   next_pc  : value the pc register loads at the next edge
module pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] next_pc
);

    // Byte offset bits of the target are intentionally dropped.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^target[1:0];

    always_comb begin
        next_pc = pc;
        if (redirect)
            next_pc = {target[31:2], 2'b00};
        else if (advance)
            next_pc = pc + PC_STEP;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction
// memory, buffers the returned word for decode, and follows redirects from
// branch_unit, discarding a response that is still in flight.
//   clk, rst           : clock, async active-high reset
//   branch, branch_target : redirect code and address
//   stall              : suppresses new requests
//   imem_req/imem_addr : request pulse and address (== pc)
//   imem_rvalid/rdata  : response strobe and instruction word
//   if_valid/if_ready  : handshake to decode
//   if_pc/if_instr     : buffered instruction and its address
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  branch,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        redirect, xfer;
    logic        issue, capture, drain;

    assign redirect  = is_redirect(branch);
    assign xfer      = if_valid & if_ready;
    // State sits at REQ throughout reset, so the request must be masked
    // by rst itself to be low immediately.
    assign imem_req  = issue & ~rst;
    assign imem_addr = pc;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        capture  = 1'b0;
        drain    = 1'b0;
        unique case (state)
            S_REQ: begin
                if (!redirect && !stall) begin
                    issue    = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect)
                    // A response arriving with the redirect is simply dropped;
                    // otherwise it is still owed and must be swallowed later.
                    state_nx = imem_rvalid ? S_REQ : S_DISCARD;
                else if (imem_rvalid) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect)
                    state_nx = S_REQ;
                else if (xfer) begin
                    drain    = 1'b1;
                    state_nx = S_REQ;
                end
            end
            S_DISCARD: begin
                // Redirects here only move pc; leave once the stale word lands.
                if (imem_rvalid)
                    state_nx = S_REQ;
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nx;
    end

    pc_next u_pc_next (
        .pc       (pc),
        .redirect (redirect),
        .target   (branch_target),
        .advance  (capture),
        .next_pc  (pc_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= NOP_INSTR;
        end else begin
            pc <= pc_nx;
            if (redirect)
                if_valid <= 1'b0;
            else if (capture) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_rdata;
            end else if (drain)
                if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed per-cycle vector table, a hand-written
// reset-mid-request sequence, then randomized traffic checked against a
// transaction-level reference model with a latency-randomized memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  branch;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .branch        (branch),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_instr);
        chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
        chk({tag, " imem_addr"}, imem_addr, e_addr);
        chk({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, e_v});
        chk({tag, " if_pc"}, if_pc, e_pc);
        chk({tag, " if_instr"}, if_instr, e_instr);
    endtask

    typedef struct {
        logic        stall;
        logic [1:0]  br;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [1:0] b, input logic [31:0] t,
                                input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    localparam int NVEC = 24;
    vec_t tbl[NVEC];

    // Reference model: transaction view of the front end.
    logic [31:0] m_pc, m_bpc, m_binstr;
    logic        m_bv;
    int          m_out;      // 0 none outstanding, 1 live, 2 to be dropped
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic model_reset();
        m_pc = 32'h0; m_bv = 1'b0; m_bpc = 32'h0; m_binstr = 32'h0000_0013;
        m_out = 0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
    endtask

    initial begin
        rst = 1'b1; branch = 2'b00; branch_target = 32'h0; stall = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b1;

        // cycle-by-cycle directed table, starting the cycle rst deasserts
        tbl[0]  = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 1, 32'h0,   0, 32'h0,   32'h13);
        tbl[1]  = mk(0, 2'd0, 32'h0,   1, 32'h11,   1, 0, 32'h0,   0, 32'h0,   32'h13);
        tbl[2]  = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h4,   1, 32'h0,   32'h11);
        tbl[3]  = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 1, 32'h4,   0, 32'h0,   32'h11);
        tbl[4]  = mk(0, 2'd0, 32'h0,   1, 32'h22,   1, 0, 32'h4,   0, 32'h0,   32'h11);
        tbl[5]  = mk(0, 2'd0, 32'h0,   0, 32'h0,    0, 0, 32'h8,   1, 32'h4,   32'h22);
        tbl[6]  = mk(0, 2'd0, 32'h0,   1, 32'hBAD,  0, 0, 32'h8,   1, 32'h4,   32'h22);
        tbl[7]  = mk(1, 2'd0, 32'h0,   0, 32'h0,    0, 0, 32'h8,   1, 32'h4,   32'h22);
        tbl[8]  = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h8,   1, 32'h4,   32'h22);
        tbl[9]  = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 1, 32'h8,   0, 32'h4,   32'h22);
        tbl[10] = mk(0, 2'd0, 32'h0,   1, 32'h33,   1, 0, 32'h8,   0, 32'h4,   32'h22);
        tbl[11] = mk(0, 2'd1, 32'h100, 0, 32'h0,    0, 0, 32'hC,   1, 32'h8,   32'h33);
        tbl[12] = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 1, 32'h100, 0, 32'h8,   32'h33);
        tbl[13] = mk(0, 2'd2, 32'h203, 0, 32'h0,    1, 0, 32'h100, 0, 32'h8,   32'h33);
        tbl[14] = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[15] = mk(0, 2'd0, 32'h0,   1, 32'hDEAD, 1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[16] = mk(1, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[17] = mk(1, 2'd3, 32'h500, 0, 32'h0,    1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[18] = mk(1, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[19] = mk(1, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[20] = mk(1, 2'd1, 32'h300, 0, 32'h0,    1, 0, 32'h200, 0, 32'h8,   32'h33);
        tbl[21] = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 1, 32'h300, 0, 32'h8,   32'h33);
        tbl[22] = mk(0, 2'd0, 32'h0,   1, 32'h44,   1, 0, 32'h300, 0, 32'h8,   32'h33);
        tbl[23] = mk(0, 2'd0, 32'h0,   0, 32'h0,    1, 0, 32'h304, 1, 32'h300, 32'h44);

        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h13);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst = 1'b0;
            stall = tbl[i].stall; branch = tbl[i].br; branch_target = tbl[i].tgt;
            imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd; if_ready = tbl[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v,
                    tbl[i].e_pc, tbl[i].e_instr);
        end

        // reset asserted while a request is outstanding
        @(negedge clk);
        stall = 1'b0; branch = 2'b00; imem_rvalid = 1'b0; if_ready = 1'b1;
        #1;
        chk("pre_rst imem_req", {31'b0, imem_req}, 32'h1);
        chk("pre_rst imem_addr", imem_addr, 32'h304);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("mid_wait_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h13);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("restart imem_req", {31'b0, imem_req}, 32'h1);
        chk("restart imem_addr", imem_addr, 32'h0);

        // randomized traffic against the reference model
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic do_rst, redir, m_req, rv;
            logic [31:0] rd, tgt;
            logic [1:0] br;
            int r;
            if (cyc != 0) @(negedge clk);
            do_rst = ($urandom_range(0, 199) == 0);
            rv = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    rv = 1'b1;
                    mem_busy = 1'b0;
                end
            end
            if (do_rst) begin
                rv = 1'b0;
                model_reset();
            end
            rd = rv ? memw(mem_addr) : $urandom;
            r = $urandom_range(0, 15);
            br = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            redir = (br == 2'b01) || (br == 2'b10);

            rst = do_rst; stall = ($urandom_range(0, 3) == 0); branch = br;
            branch_target = tgt; imem_rvalid = rv; imem_rdata = rd;
            if_ready = ($urandom_range(0, 2) != 0);

            m_req = !do_rst && (m_out == 0) && !m_bv && !stall && !redir;
            #1;
            chk_all($sformatf("rnd%0d", cyc), m_req, m_pc, m_bv, m_bpc, m_binstr);

            if (!do_rst) begin
                if (m_req) begin
                    mem_busy = 1'b1;
                    mem_cnt  = $urandom_range(1, 3);
                    mem_addr = m_pc;
                end
                if (redir) begin
                    m_pc  = {tgt[31:2], 2'b00};
                    m_bv  = 1'b0;
                    m_out = (m_out != 0 && !rv) ? 2 : 0;
                end else if (m_out == 1 && rv) begin
                    m_bv = 1'b1; m_bpc = m_pc; m_binstr = rd;
                    m_pc = m_pc + 32'd4;
                    m_out = 0;
                end else if (m_out == 2 && rv) begin
                    m_out = 0;
                end else if (m_bv && if_ready) begin
                    m_bv = 1'b0;
                end else if (m_req) begin
                    m_out = 1;
                end
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-high.
REQ-004 branch  input  2  redirect code from branch_unit (BR_NONE=00, BR_TAKEN=01, BR_JUMP=10, 11 reserved).
REQ-005 branch_target  input  32  redirect address; valid when branch is 01 or 10.
REQ-006 stall  input  1  hazard hold; suppresses new fetch requests.
REQ-007 imem_req  output  1  one-cycle fetch request pulse.
REQ-008 imem_addr  output  32  fetch address; equals pc.
REQ-009 imem_rvalid  input  1  instruction return strobe, at least 1 cycle after imem_req.
REQ-010 imem_rdata  input  32  returned instruction word.
REQ-011 if_valid  output  1  registered; if_pc/if_instr hold a valid instruction.
REQ-012 if_ready  input  1  decode accepts; transfer = if_valid & if_ready.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 if_instr  output  32  fetched instruction.

Function
REQ-015 FSM states: REQ, WAIT, HOLD, DISCARD; at most one request outstanding.
REQ-016 Redirect = branch in {01, 10}; code 00 or 11 is no redirect.
REQ-017 REQ: imem_req = 1 iff no stall and no redirect this cycle; on issue, go to WAIT; otherwise stay.
REQ-018 WAIT: on imem_rvalid without redirect, capture if_instr <= imem_rdata and if_pc <= pc, set if_valid, pc <= pc+4 (mod 2^32 wrap), go to HOLD.
REQ-019 HOLD: on transfer, clear if_valid and go to REQ; otherwise hold outputs unchanged.
REQ-020 Redirect in any state: pc <= {branch_target[31:2], 2'b00}, if_valid cleared next cycle.
REQ-021 Redirect next state: WAIT without imem_rvalid goes to DISCARD; every other case, including WAIT with imem_rvalid the same cycle (data dropped), goes to REQ.
REQ-022 DISCARD: on imem_rvalid, drop data and go to REQ; a redirect here updates pc and stays in DISCARD.
REQ-023 Redirect beats stall and beats the HOLD transfer; a transfer in the redirect cycle is wrong-path and decode is flushed by the same branch signal.
REQ-024 imem_rvalid in REQ or HOLD is ignored.
REQ-025 stall does not affect WAIT, HOLD or DISCARD.
REQ-026 Minimum latency: request to if_valid is 2 cycles; redirect to first imem_req at target is 1 cycle (from REQ or HOLD).

Reset
REQ-027 Asserting rst, at any time, immediately forces: state REQ, pc RESET_PC, imem_req 0, if_valid 0, if_pc 0, if_instr 32'h0000_0013 (NOP).
REQ-028 Reset in WAIT abandons the request; instruction memory shares rst, so no stale imem_rvalid follows.
REQ-029 The first imem_req is in the first cycle after rst deasserts, unless stall is high.

Structure
REQ-030 The BR_NONE/BR_TAKEN/BR_JUMP encodings live in the shared package alongside the ALU compare-op encodings, also used by branch_unit.
REQ-031 FSM state encodings are local to fetch_unit.
REQ-032 A single sub-module, pc_next, computes the next pc (pc+4 or aligned target).

Verification
REQ-033 Reset release, RESET_PC=0, memory returns 1 cycle later, if_ready=1 -> if_pc 0, 4, 8 in order; imem_addr matches each.
REQ-034 In HOLD, if_ready=0 for 3 cycles -> if_valid, if_pc and if_instr stable and no imem_req; if_ready=1 -> next request at pc+4.
REQ-035 branch=01 with target 32'h0000_0100 in HOLD -> if_valid 0 next cycle; next imem_addr = 32'h100.
REQ-036 branch=10 with target 32'h0000_0203 while in WAIT, rvalid 2 cycles later -> response dropped; next imem_addr = 32'h200.
REQ-037 stall=1 in REQ for 4 cycles -> imem_req 0; stall and branch=01 together -> pc takes target and no request that cycle.
REQ-038 rst pulsed mid-WAIT -> outputs at reset values immediately; fetch restarts at RESET_PC.
